// File: rtl/input_signal_sorter.sv
// -----------------------------------------------------------------------------
// input_signal_sorter
//   Front-end reorder stage for the radix-2 FFT datapath. Takes D_WIDTH
//   samples in natural order and registers them in bit-reversed index order.
//   The permutation is pure wiring. The only logic is one output register per
//   lane, so the latency is one clock and the stage accepts one vector per
//   clock.
//
// Parameters
//   D_WIDTH      number of samples (FFT points); must equal 2**LOG_2_WIDTH
//   LOG_2_WIDTH  index width used for bit reversal
//   SAMPLE_WIDTH bits per sample
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every output lane to 0
//   input_sig  natural-order samples; lane i at [SAMPLE_WIDTH*i +: SAMPLE_WIDTH]
//   output_sig registered samples in bit-reversed order, same lane packing;
//              output lane j = input lane rev(j)
// -----------------------------------------------------------------------------

// One output lane: a SAMPLE_WIDTH-bit register. The sample is copied
// unchanged; no bits are reordered.
module input_signal_sorter_lane #(
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SAMPLE_WIDTH-1:0] d,
   output logic [SAMPLE_WIDTH-1:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= '0;
      else     q <= d;
   end
endmodule

module input_signal_sorter #(
   parameter int D_WIDTH      = 64,
   parameter int LOG_2_WIDTH  = 6,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [SAMPLE_WIDTH*D_WIDTH-1:0] input_sig,
   output logic [SAMPLE_WIDTH*D_WIDTH-1:0] output_sig
);

   // Reverses the low LOG_2_WIDTH bits of idx. This runs only at elaboration,
   // to produce constant lane indices.
   function automatic int rev_idx(input int idx);
      int r;
      r = 0;
      for (int k = 0; k < LOG_2_WIDTH; k++)
         if (((idx >> k) & 1) != 0) r = r | (1 << (LOG_2_WIDTH - 1 - k));
      return r;
   endfunction

   // Stop elaboration on a configuration that is not a power-of-two FFT size.
   if (LOG_2_WIDTH < 1 || D_WIDTH != (1 << LOG_2_WIDTH)) begin : g_bad_cfg
      $error("input_signal_sorter: D_WIDTH (%0d) must equal 2**LOG_2_WIDTH (%0d), LOG_2_WIDTH >= 1",
             D_WIDTH, LOG_2_WIDTH);
   end

   // Each output lane j reads the input lane at rev(j). The source index is a
   // constant, so the mux becomes fixed wiring.
   for (genvar j = 0; j < D_WIDTH; j++) begin : g_lane
      localparam int SRC = rev_idx(j);
      input_signal_sorter_lane #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_lane (
         .clk (clk),
         .rst (rst),
         .d   (input_sig[SAMPLE_WIDTH*SRC +: SAMPLE_WIDTH]),
         .q   (output_sig[SAMPLE_WIDTH*j +: SAMPLE_WIDTH])
      );
   end

endmodule

// File: tb/tb_input_signal_sorter.sv
module tb_input_signal_sorter;
   localparam int N   = 64;
   localparam int LG  = 6;
   localparam int SW  = 16;
   localparam int VW  = N * SW;
   localparam int NS  = 8;
   localparam int VWS = NS * SW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [VW-1:0]  input_sig  = '0;
   logic [VW-1:0]  output_sig;
   logic [VWS-1:0] input_small = '0;
   logic [VWS-1:0] output_small;

   int checks = 0;
   int errors = 0;
   logic [VW-1:0] sb[$];

   always #5 clk = ~clk;

   input_signal_sorter #(.D_WIDTH(N), .LOG_2_WIDTH(LG), .SAMPLE_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .input_sig(input_sig), .output_sig(output_sig));

   input_signal_sorter #(.D_WIDTH(NS), .LOG_2_WIDTH(3), .SAMPLE_WIDTH(SW)) dut_small (
      .clk(clk), .rst(rst), .input_sig(input_small), .output_sig(output_small));

   // Reference model: reverse the digits of the index in base 2, then move
   // whole samples between lanes.
   function automatic int bitrev(input int j, input int bits);
      int x, r;
      x = j; r = 0;
      repeat (bits) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
      logic [VW-1:0] o;
      o = '0;
      for (int j = 0; j < N; j++) o[j*SW +: SW] = v[bitrev(j, LG)*SW +: SW];
      return o;
   endfunction

   function automatic logic [VW-1:0] ramp();
      logic [VW-1:0] v;
      for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(i);
      return v;
   endfunction

   task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < N; i++)
            if (act[i*SW +: SW] !== exp[i*SW +: SW]) begin
               $display("FAIL %s: lane %0d got %h expected %h", name, i, act[i*SW +: SW], exp[i*SW +: SW]);
               break;
            end
      end
   endtask

   task automatic check_val(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Put a vector on the input before the next rising edge, and queue the
   // response the model predicts for that edge.
   task automatic drive(input logic [VW-1:0] v);
      @(negedge clk);
      input_sig = v;
      sb.push_back(model(v));
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'($urandom);
      return v;
   endfunction

   // Monitor: the output is sampled shortly after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) check_vec("sb_vector", output_sig, sb.pop_front());
      end
   end

   initial begin
      logic [VW-1:0] v, cap;
      int small_exp[NS];
      small_exp = '{0, 4, 2, 6, 1, 5, 3, 7};

      // Reset held with the ramp on the input: the output must stay 0.
      rst = 1'b1;
      input_sig = ramp();
      for (int i = 0; i < NS; i++) input_small[i*SW +: SW] = SW'(i);
      repeat (5) begin
         @(posedge clk); #1;
         check_vec("reset_hold", output_sig, '0);
      end
      checks++;
      if (output_small !== '0) begin
         errors++;
         $display("FAIL reset_small: got %h expected 0", output_small);
      end

      // Release reset. The first edge captures the ramp.
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(model(ramp()));
      @(posedge clk); #2;
      check_val("ramp_l0",  output_sig[0*SW +: SW],  16'd0);
      check_val("ramp_l1",  output_sig[1*SW +: SW],  16'd32);
      check_val("ramp_l2",  output_sig[2*SW +: SW],  16'd16);
      check_val("ramp_l3",  output_sig[3*SW +: SW],  16'd48);
      check_val("ramp_l31", output_sig[31*SW +: SW], 16'd62);
      check_val("ramp_l32", output_sig[32*SW +: SW], 16'd1);
      check_val("ramp_l62", output_sig[62*SW +: SW], 16'd31);
      check_val("ramp_l63", output_sig[63*SW +: SW], 16'd63);
      for (int j = 0; j < NS; j++)
         check_val("small_ramp", output_small[j*SW +: SW], SW'(small_exp[j]));

      // Latency and pipelining: two different vectors on back-to-back edges.
      drive(ramp());
      for (int i = 0; i < N; i++) v[i*SW +: SW] = 16'hFFFF - SW'(i);
      drive(v);
      @(posedge clk); #2;
      check_val("pipe_l1", output_sig[1*SW +: SW], 16'hFFDF);
      check_val("pipe_l2", output_sig[2*SW +: SW], 16'hFFEF);

      // Data transparency: the lane tag in the high bits, plus MSB-set words.
      for (int i = 0; i < N; i++) v[i*SW +: SW] = {6'(i), 10'h2A5};
      v[5*SW +: SW]  = 16'h8000;
      v[40*SW +: SW] = 16'h7FFF;
      v[63*SW +: SW] = 16'h8001;
      drive(v);

      // Involution: the captured output, fed back in, gives the ramp again.
      drive(ramp());
      @(posedge clk); #2;
      cap = output_sig;
      @(negedge clk);
      input_sig = cap;
      sb.push_back(ramp());

      // Randomized traffic, one vector per clock.
      repeat (24) drive(rand_vec());

      // Asserting reset between edges clears the output without an edge and
      // drops the vector that was waiting for the next edge.
      @(negedge clk);
      input_sig = rand_vec();
      #2 rst = 1'b1;
      #1 check_vec("async_rst", output_sig, '0);
      @(posedge clk); #1;
      check_vec("rst_discard", output_sig, '0);

      // The first edge after reset falls captures the input present then.
      @(negedge clk);
      rst = 1'b0;
      v = rand_vec();
      input_sig = v;
      sb.push_back(model(v));
      repeat (6) drive(rand_vec());

      // Drain the scoreboard, with a bound on the wait.
      for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
